// File: rtl/countdown_display.sv
// rtl/countdown_display.sv - game-clock countdown with registered BCD digits and 7-segment outputs
module countdown_display #(
    parameter int START_SECS = 30,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Load,
    input  logic [6:0] load_secs,
    output logic [6:0] secs_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] hex_tens,
    output logic [6:0] hex_ones,
    output logic       running,
    output logic       expired,
    output logic       time_up
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [6:0] START_V = 7'(START_SECS);
    localparam logic [3:0] START_T = 4'(START_SECS / 10);
    localparam logic [3:0] START_O = 4'(START_SECS % 10);

    state_t     state_q, state_d;
    logic [6:0] secs_q, secs_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       tick_q;
    logic       running_q, running_d;
    logic       expired_q, expired_d;
    logic       time_up_q, time_up_d;

    logic       tick_rise;
    logic [6:0] load_clamped;
    logic [6:0] load_rem;
    logic [3:0] load_tens;
    logic [3:0] load_ones;

    // Right after reset the state is IDLE, which ignores edges, so no spurious count.
    assign tick_rise    = tick & ~tick_q;
    assign load_clamped = (load_secs > 7'd99) ? 7'd99 : load_secs;

    always_comb begin
        load_tens = 4'd0;
        load_rem  = load_clamped;
        for (int t = 1; t <= 9; t++) begin
            if (load_clamped >= 7'(10 * t)) begin
                load_tens = 4'(t);
                load_rem  = load_clamped - 7'(10 * t);
            end
        end
        load_ones = 4'(load_rem);
    end

    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        time_up_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (Load) begin
                    secs_d = load_clamped;
                    tens_d = load_tens;
                    ones_d = load_ones;
                end else if (Start) begin
                    if (secs_q != 7'd0) begin
                        state_d = RUNNING;
                    end else begin
                        state_d   = EXPIRED;
                        time_up_d = 1'b1;
                    end
                end
            end
            RUNNING: begin
                if (Pause) begin
                    state_d = PAUSED;
                end else if (tick_rise) begin
                    secs_d = secs_q - 7'd1;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                    if (secs_q == 7'd1) begin
                        state_d   = EXPIRED;
                        time_up_d = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (Load) begin
                    secs_d  = load_clamped;
                    tens_d  = load_tens;
                    ones_d  = load_ones;
                    state_d = IDLE;
                end else if (Start && !Pause) begin
                    state_d = RUNNING;
                end
            end
            EXPIRED: begin
                if (Load) begin
                    secs_d  = load_clamped;
                    tens_d  = load_tens;
                    ones_d  = load_ones;
                    state_d = IDLE;
                end else if (Start) begin
                    secs_d  = START_V;
                    tens_d  = START_T;
                    ones_d  = START_O;
                    state_d = RUNNING;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUNNING);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            secs_q    <= START_V;
            tens_q    <= START_T;
            ones_q    <= START_O;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            secs_q    <= secs_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            tick_q    <= tick;
            running_q <= running_d;
            expired_q <= expired_d;
            time_up_q <= time_up_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign hex_tens  = (BLANK_LEAD && tens_q == 4'd0) ? 7'b1111111 : seg7(tens_q);
    assign hex_ones  = seg7(ones_q);
    assign secs_left = secs_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign time_up   = time_up_q;

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
- Consumer end of the one-second tick interface driven by the game timer.
- Counts the game clock down, one second per tick pulse received on `tick`.
- Keeps the remaining seconds as two registered BCD digits and drives two active-low 7-segment digit outputs.
- Raises `time_up` when the clock reaches zero; game control logic uses it to end the round.

Parameters:
- START_SECS, 30, value loaded at reset and on restart from EXPIRED; legal range 1..99.
- BLANK_LEAD, 1, 1 = tens digit blanked (all segments off) when it is 0.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous reset, active-low (Reset==0 at a rising edge of Clk resets).
- tick  input  1  one-second pulse from the timer; rising edge counted.
- Start  input  1  start / resume / restart request, level sampled each cycle.
- Pause  input  1  pause request, level sampled each cycle.
- Load  input  1  load request for load_secs.
- load_secs  input  7  binary seconds to load; values >99 clamp to 99.
- secs_left  output  7  remaining seconds, binary.
- bcd_tens  output  4  tens digit of secs_left.
- bcd_ones  output  4  ones digit of secs_left.
- hex_tens  output  7  active-low segments {g,f,e,d,c,b,a}, tens digit.
- hex_ones  output  7  active-low segments, ones digit.
- running  output  1  high in RUNNING.
- expired  output  1  high in EXPIRED.
- time_up  output  1  one-cycle pulse on entry to EXPIRED.

Behaviour:
- Reset values: state IDLE; secs_left=START_SECS with matching bcd; running=0; expired=0; time_up=0; tick_q=0.
- Edge detect: tick_q registers `tick` every cycle. tick_rise = tick & ~tick_q.
  - A tick held high for N cycles counts once.
  - The first cycle after reset cannot produce a spurious edge.
- States: IDLE, RUNNING, PAUSED, EXPIRED. running and expired are registered state decodes, valid in the same cycle the state is.
- IDLE:
  - Load: secs_left <= clamp(load_secs); stay IDLE.
  - Else Start with secs_left!=0: go to RUNNING.
  - Else Start with secs_left==0: go to EXPIRED and pulse time_up.
  - Load has priority over Start in the same cycle.
  - tick_rise is ignored.
- RUNNING:
  - Pause: go to PAUSED. A tick_rise in the same cycle is dropped.
  - Else tick_rise with secs_left>1: decrement by 1.
  - Else tick_rise with secs_left==1: secs_left <= 0; go to EXPIRED; time_up=1 in the following cycle only.
  - Load and Start are ignored.
- PAUSED:
  - Load: load the clamped value and go to IDLE.
  - Else Start: go to RUNNING.
  - Pause and Start both high: stay PAUSED.
  - Ticks are ignored.
- EXPIRED:
  - secs_left holds 0.
  - Load: load the clamped value and go to IDLE.
  - Else Start: secs_left <= START_SECS and go to RUNNING.
  - time_up is deasserted after its single cycle.
- BCD counting:
  - bcd_tens/bcd_ones are held as registers, updated on the same edge as secs_left, never lagging it.
  - Decrement: ones 0→9 with tens-1; otherwise ones-1.
  - On load, digits come from the clamped value: tens = v/10, ones = v%10 (a small constant table or subtract loop is acceptable; it must settle in one cycle).
- 7-segment outputs: combinational from the bcd registers, standard 0-9 patterns.
  - Examples: 0 = 7'b1000000, 1 = 7'b1111001, 9 = 7'b0010000.
  - Codes >9 give all segments off.
  - With BLANK_LEAD=1 and tens==0, hex_tens = 7'b1111111.
- Reset mid-operation (any state) forces all reset values on the next edge. A pending time_up is cancelled.

Test Plan:
- Reset low 2 cycles, release. Then Start=1 for 1 cycle → running=1 next cycle; secs_left=30, bcd 3/0, hex_tens=7'b0110000, hex_ones=7'b1000000.
- RUNNING from 30: 31 single-cycle ticks, then one tick held 5 cycles.
  - After tick 1: secs_left=29, bcd 2/9.
  - After tick 30: secs_left=0, time_up high exactly 1 cycle, expired=1.
  - Tick 31 and the held tick: no change.
- Load=1 with load_secs=120 in IDLE → secs_left=99, bcd 9/9. Load=1 and Start=1 together → value loaded, state stays IDLE.
- Load load_secs=5, Start, two ticks (secs_left=3), Pause with a simultaneous tick → secs_left stays 3.
  - Three further ticks → still 3.
  - Start → RUNNING; next tick → 2. With BLANK_LEAD=1, hex_tens=7'b1111111.
- In RUNNING with secs_left=1, assert Reset=0 in the same cycle as a tick → next cycle secs_left=30, state IDLE, time_up=0 throughout.
- Load load_secs=0, Start → EXPIRED next cycle with one time_up pulse. Start again → secs_left=30, running=1.
